// File: rtl/mac_pkg.sv
// Shared types and default sizing for the MAC host controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac_pkg;

  localparam int DEF_M       = 4;
  localparam int DEF_K       = 4;
  localparam int DEF_N       = 4;
  localparam int DEF_DWI     = 8;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WRITE,
    WAIT_DONE,
    READ,
    RESP
  } state_t;

endpackage

// File: rtl/mac_host_ctrl_if.sv
// MAC-side bus between the host controller (master) and the MAC block (slave).
// Latency: n/a (wires only).
// Backpressure: host2block_rdy stalls the request, block2host_val gates the result read.
interface mac_host_ctrl_if #(
  parameter int M   = 4,
  parameter int K   = 4,
  parameter int N   = 4,
  parameter int DWI = 8,
  parameter int DWF = 16
);

  logic                      host2block_val;
  logic                      host2block_rdy;
  logic [M*K-1:0][DWI-1:0]   a_data_in_ext;
  logic [N*K-1:0][DWI-1:0]   b_data_in_ext;
  logic                      a_b_we_ext;
  logic                      c_re_ext;
  logic [M*N-1:0][DWF-1:0]   c_data_out_ext;
  logic                      mac_done;
  logic                      block2host_val;
  logic                      block2host_rdy;

  modport master (
    output host2block_val, a_data_in_ext, b_data_in_ext, a_b_we_ext, c_re_ext,
           block2host_rdy,
    input  host2block_rdy, c_data_out_ext, mac_done, block2host_val
  );

  modport slave (
    input  host2block_val, a_data_in_ext, b_data_in_ext, a_b_we_ext, c_re_ext,
           block2host_rdy,
    output host2block_rdy, c_data_out_ext, mac_done, block2host_val
  );

endinterface

// File: rtl/mac_transpose.sv
// Transposes a row-major KxN matrix into row-major NxK: out[j*K+k] = in[k*N+j].
// Latency: combinational.
// Backpressure: none.
module mac_transpose #(
  parameter int K = 4,
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic [K*N-1:0][W-1:0] b_in,
  output logic [N*K-1:0][W-1:0] b_out
);

  for (genvar j = 0; j < N; j++) begin : g_col
    for (genvar k = 0; k < K; k++) begin : g_row
      assign b_out[j*K+k] = b_in[k*N+j];
    end
  end

endmodule

// File: rtl/mac_host_ctrl.sv
// Host-side controller: accepts an A/B command, writes operands to the MAC, reads C back.
// Latency: command accept to host2block_val is 1 cycle; result held until res_rdy.
// Backpressure: cmd_rdy only in IDLE; MAC-side waits bounded by TIMEOUT_CYCLES (sets sticky err).
module mac_host_ctrl
  import mac_pkg::*;
#(
  parameter int param_M            = DEF_M,
  parameter int param_K            = DEF_K,
  parameter int param_N            = DEF_N,
  parameter int DATA_WIDTH_INITIAL = DEF_DWI,
  parameter int DATA_WIDTH_FINAL   = DATA_WIDTH_INITIAL * 2,
  parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  cmd_val,
  output logic                                                  cmd_rdy,
  input  logic [param_M*param_K-1:0][DATA_WIDTH_INITIAL-1:0]    a_mat,
  input  logic [param_K*param_N-1:0][DATA_WIDTH_INITIAL-1:0]    b_mat,
  output logic                                                  res_val,
  input  logic                                                  res_rdy,
  output logic [param_M*param_N-1:0][DATA_WIDTH_FINAL-1:0]      res_c,
  output logic                                                  err,
  mac_host_ctrl_if.master                                       mac
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          expire;
  logic          timeout;
  logic          capture;
  logic          accept;

  logic [param_M*param_K-1:0][DATA_WIDTH_INITIAL-1:0] a_reg;
  logic [param_N*param_K-1:0][DATA_WIDTH_INITIAL-1:0] b_reg;
  logic [param_N*param_K-1:0][DATA_WIDTH_INITIAL-1:0] b_t;

  mac_transpose #(
    .K (param_K),
    .N (param_N),
    .W (DATA_WIDTH_INITIAL)
  ) u_transpose (
    .b_in  (b_mat),
    .b_out (b_t)
  );

  // Expiry fires on the cycle the in-state count would reach the limit.
  assign cnt_inc = cnt + CW'(1);
  assign expire  = (cnt_inc == TO_LIMIT);
  assign accept  = (state == IDLE) && cmd_val;

  // Next state and all handshake strobes, decoded from the current state.
  always_comb begin
    state_nxt          = state;
    cmd_rdy            = 1'b0;
    res_val            = 1'b0;
    timeout            = 1'b0;
    capture            = 1'b0;
    mac.host2block_val = 1'b0;
    mac.a_b_we_ext     = 1'b0;
    mac.c_re_ext       = 1'b0;
    mac.block2host_rdy = 1'b0;
    mac.a_data_in_ext  = '0;
    mac.b_data_in_ext  = '0;
    case (state)
      IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_val) state_nxt = REQ;
      end
      REQ: begin
        mac.host2block_val = 1'b1;
        if (mac.host2block_rdy) begin
          state_nxt = WRITE;
        end else if (expire) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        mac.host2block_val = 1'b1;
        mac.a_b_we_ext     = 1'b1;
        mac.a_data_in_ext  = a_reg;
        mac.b_data_in_ext  = b_reg;
        state_nxt          = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (mac.mac_done) begin
          state_nxt = READ;
        end else if (expire) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      READ: begin
        mac.c_re_ext       = 1'b1;
        mac.block2host_rdy = 1'b1;
        if (mac.block2host_val) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else if (expire) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      RESP: begin
        res_val = 1'b1;
        if (res_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and per-state wait counter (restarts on every transition, saturates).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (cnt != TO_LIMIT) cnt <= cnt_inc;
    end
  end

  // Operand capture at command accept; B is stored already transposed.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (accept) begin
      a_reg <= a_mat;
      b_reg <= b_t;
    end
  end

  // Result capture on the first valid read beat, and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_c <= '0;
      err   <= 1'b0;
    end else begin
      if (capture) res_c <= mac.c_data_out_ext;
      if (accept) err <= 1'b0;
      else if (timeout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_host_ctrl.sv
// Directed bench for mac_host_ctrl; the bench plays the MAC side by hand.
// Latency: n/a.
// Backpressure: exercised via delayed host2block_rdy, block2host_val and res_rdy.
module tb_mac_host_ctrl;

  logic clk;
  logic rst;
  logic cmd_val;
  logic cmd_rdy;
  logic [15:0][7:0]  a_mat;
  logic [15:0][7:0]  b_mat;
  logic res_val;
  logic res_rdy;
  logic [15:0][15:0] res_c;
  logic err;

  int compared   = 0;
  int mismatched = 0;
  int we_cnt     = 0;
  int rv_cnt     = 0;

  logic [15:0][7:0]  cap_a;
  logic [15:0][7:0]  cap_bt;
  logic [15:0][15:0] c_exp;
  logic [15:0][15:0] c_snap;

  mac_host_ctrl_if #(.M(4), .K(4), .N(4), .DWI(8), .DWF(16)) bus ();

  mac_host_ctrl #(
    .param_M            (4),
    .param_K            (4),
    .param_N            (4),
    .DATA_WIDTH_INITIAL (8),
    .DATA_WIDTH_FINAL   (16),
    .TIMEOUT_CYCLES     (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd_val (cmd_val),
    .cmd_rdy (cmd_rdy),
    .a_mat   (a_mat),
    .b_mat   (b_mat),
    .res_val (res_val),
    .res_rdy (res_rdy),
    .res_c   (res_c),
    .err     (err),
    .mac     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.a_b_we_ext) we_cnt++;
    if (res_val) rv_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference product from the user's row-major A and B.
  function automatic logic [15:0][15:0] matmul(input logic [15:0][7:0] a, input logic [15:0][7:0] b);
    logic [15:0][15:0] c;
    c = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++)
          c[i*4+j] = c[i*4+j] + 16'(a[i*4+k]) * 16'(b[k*4+j]);
    return c;
  endfunction

  // MAC model: what the MAC block computes from the operand buses (B arrives transposed).
  function automatic logic [15:0][15:0] mac_model(input logic [15:0][7:0] a, input logic [15:0][7:0] bt);
    logic [15:0][15:0] c;
    c = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++)
          c[i*4+j] = c[i*4+j] + 16'(a[i*4+k]) * 16'(bt[j*4+k]);
    return c;
  endfunction

  initial begin
    rst                  = 1'b1;
    cmd_val              = 1'b0;
    res_rdy              = 1'b0;
    a_mat                = '0;
    b_mat                = '0;
    bus.host2block_rdy   = 1'b0;
    bus.mac_done         = 1'b0;
    bus.block2host_val   = 1'b0;
    bus.c_data_out_ext   = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state.
    chk("rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
    chk("rst_res_val", 64'(res_val), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_h2b_val", 64'(bus.host2block_val), 64'd0);
    chk("rst_we", 64'(bus.a_b_we_ext), 64'd0);
    chk("rst_c_re", 64'(bus.c_re_ext), 64'd0);
    chk("rst_res_c", 64'(res_c[0]), 64'd0);

    // Stray MAC events in IDLE are ignored.
    bus.mac_done       = 1'b1;
    bus.block2host_val = 1'b1;
    tick();
    bus.mac_done       = 1'b0;
    bus.block2host_val = 1'b0;
    chk("idle_ignore_cmd_rdy", 64'(cmd_rdy), 64'd1);
    chk("idle_ignore_c_re", 64'(bus.c_re_ext), 64'd0);

    // Transaction 1: A[i]=i, B[i]=i, host2block_rdy held off 5 cycles.
    for (int i = 0; i < 16; i++) begin
      a_mat[i] = 8'(i);
      b_mat[i] = 8'(i);
    end
    we_cnt  = 0;
    cmd_val = 1'b1;
    tick();
    cmd_val = 1'b0;
    chk("t1_cmd_rdy_low", 64'(cmd_rdy), 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t1_req_h2b_val", 64'(bus.host2block_val), 64'd1);
      chk("t1_req_we", 64'(bus.a_b_we_ext), 64'd0);
      chk("t1_req_bbus", 64'(bus.b_data_in_ext[1]), 64'd0);
      if (i == 4) bus.host2block_rdy = 1'b1;
      tick();
    end
    bus.host2block_rdy = 1'b0;
    chk("t1_write_we", 64'(bus.a_b_we_ext), 64'd1);
    chk("t1_write_h2b", 64'(bus.host2block_val), 64'd1);
    chk("t1_write_b1", 64'(bus.b_data_in_ext[1]), 64'd4);
    chk("t1_write_a5", 64'(bus.a_data_in_ext[5]), 64'd5);
    cap_a  = bus.a_data_in_ext;
    cap_bt = bus.b_data_in_ext;
    tick();
    chk("t1_wait_we", 64'(bus.a_b_we_ext), 64'd0);
    chk("t1_wait_h2b", 64'(bus.host2block_val), 64'd0);
    chk("t1_wait_bbus", 64'(bus.b_data_in_ext[1]), 64'd0);
    tick();
    tick();
    bus.mac_done = 1'b1;
    tick();
    bus.mac_done       = 1'b0;
    bus.c_data_out_ext = mac_model(cap_a, cap_bt);
    // block2host_val withheld for 3 READ cycles, offered on the 4th.
    for (int i = 0; i < 4; i++) begin
      chk("t1_read_c_re", 64'(bus.c_re_ext), 64'd1);
      chk("t1_read_b2h_rdy", 64'(bus.block2host_rdy), 64'd1);
      if (i == 3) bus.block2host_val = 1'b1;
      tick();
    end
    bus.block2host_val = 1'b0;
    bus.c_data_out_ext = '1;
    chk("t1_resp_res_val", 64'(res_val), 64'd1);
    chk("t1_resp_c_re", 64'(bus.c_re_ext), 64'd0);
    chk("t1_res_c0", 64'(res_c[0]), 64'd56);
    chk("t1_res_c15", 64'(res_c[15]), 64'd506);
    c_exp = matmul(a_mat, b_mat);
    for (int e = 0; e < 16; e++) chk("t1_res_c_elem", 64'(res_c[e]), 64'(c_exp[e]));
    chk("t1_we_pulses", 64'(we_cnt), 64'd1);

    // Hold the result 10 cycles with a competing command pending.
    c_snap  = res_c;
    cmd_val = 1'b1;
    a_mat   = '1;
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_res_val", 64'(res_val), 64'd1);
      chk("t2_hold_cmd_rdy", 64'(cmd_rdy), 64'd0);
      chk("t2_hold_res_c15", 64'(res_c[15]), 64'(c_snap[15]));
      tick();
    end
    cmd_val = 1'b0;
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
    chk("t2_done_res_val", 64'(res_val), 64'd0);
    chk("t2_done_cmd_rdy", 64'(cmd_rdy), 64'd1);
    chk("t2_done_h2b", 64'(bus.host2block_val), 64'd0);

    // Timeout in WAIT_DONE: mac_done never arrives.
    rv_cnt  = 0;
    cmd_val = 1'b1;
    tick();
    cmd_val            = 1'b0;
    bus.host2block_rdy = 1'b1;
    tick();
    bus.host2block_rdy = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk("t3_wait_err", 64'(err), 64'd0);
      chk("t3_wait_cmd_rdy", 64'(cmd_rdy), 64'd0);
      tick();
    end
    chk("t3_last_wait_cmd_rdy", 64'(cmd_rdy), 64'd0);
    tick();
    chk("t3_to_err", 64'(err), 64'd1);
    chk("t3_to_cmd_rdy", 64'(cmd_rdy), 64'd1);
    chk("t3_to_res_val_seen", 64'(rv_cnt), 64'd0);
    tick();
    chk("t3_err_sticky", 64'(err), 64'd1);

    // Next command clears err; then reset mid-WAIT_DONE.
    cmd_val = 1'b1;
    tick();
    cmd_val = 1'b0;
    chk("t4_err_cleared", 64'(err), 64'd0);
    bus.host2block_rdy = 1'b1;
    tick();
    bus.host2block_rdy = 1'b0;
    tick();
    chk("t4_in_wait_cmd_rdy", 64'(cmd_rdy), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
    chk("t4_rst_res_c15", 64'(res_c[15]), 64'd0);
    chk("t4_rst_err", 64'(err), 64'd0);
    chk("t4_rst_h2b", 64'(bus.host2block_val), 64'd0);

    // Full transaction after reset with immediate handshakes and fresh data.
    for (int i = 0; i < 16; i++) begin
      a_mat[i] = 8'(i + 1);
      b_mat[i] = 8'(16 - i);
    end
    cmd_val = 1'b1;
    tick();
    cmd_val            = 1'b0;
    bus.host2block_rdy = 1'b1;
    tick();
    bus.host2block_rdy = 1'b0;
    chk("t5_write_we", 64'(bus.a_b_we_ext), 64'd1);
    chk("t5_write_b1", 64'(bus.b_data_in_ext[1]), 64'd12);
    cap_a  = bus.a_data_in_ext;
    cap_bt = bus.b_data_in_ext;
    bus.mac_done = 1'b1;
    tick();
    tick();
    bus.mac_done       = 1'b0;
    bus.c_data_out_ext = mac_model(cap_a, cap_bt);
    bus.block2host_val = 1'b1;
    chk("t5_read_c_re", 64'(bus.c_re_ext), 64'd1);
    tick();
    bus.block2host_val = 1'b0;
    // C[0][0] = 1*16 + 2*12 + 3*8 + 4*4 = 80.
    chk("t5_res_c0", 64'(res_c[0]), 64'd80);
    c_exp = matmul(a_mat, b_mat);
    for (int e = 0; e < 16; e++) chk("t5_res_c_elem", 64'(res_c[e]), 64'(c_exp[e]));
    res_rdy = 1'b1;
    chk("t5_resp_res_val", 64'(res_val), 64'd1);
    tick();
    res_rdy = 1'b0;
    chk("t5_idle_cmd_rdy", 64'(cmd_rdy), 64'd1);
    chk("t5_idle_err", 64'(err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mac_host_ctrl.md
MAC_HOST_CTRL -- requirements
Module: mac_host_ctrl

Interface
REQ-001 SHALL have parameter param_M, default 4: rows of A and C.
REQ-002 SHALL have parameter param_K, default 4: columns of A and rows of B.
REQ-003 SHALL have parameter param_N, default 4: columns of B and C.
REQ-004 SHALL have parameter DATA_WIDTH_INITIAL, default 8: A/B element width.
REQ-005 SHALL have parameter DATA_WIDTH_FINAL, default DATA_WIDTH_INITIAL*2: C element width.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum wait in any MAC-side wait state.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port cmd_val, input, 1 bit: user command valid.
REQ-010 SHALL have port cmd_rdy, output, 1 bit: controller accepts a command.
REQ-011 SHALL have port a_mat, input, [M*K][DWI] packed: A, row-major, element (i,k) at i*K+k.
REQ-012 SHALL have port b_mat, input, [K*N][DWI] packed: B, row-major, element (k,j) at k*N+j.
REQ-013 SHALL have port res_val, output, 1 bit: result valid.
REQ-014 SHALL have port res_rdy, input, 1 bit: user accepts the result.
REQ-015 SHALL have port res_c, output, [M*N][DWF] packed: captured C.
REQ-016 SHALL have port err, output, 1 bit: sticky timeout flag.
REQ-017 SHALL have port host2block_val, output, 1 bit: request to MAC.
REQ-018 SHALL have port host2block_rdy, input, 1 bit: MAC ready for data.
REQ-019 SHALL have ports a_data_in_ext / b_data_in_ext, outputs, [M*K][DWI] / [N*K][DWI]: operand buses.
REQ-020 SHALL have port a_b_we_ext, output, 1 bit: operand write strobe.
REQ-021 SHALL have port c_re_ext, output, 1 bit: result read strobe.
REQ-022 SHALL have port c_data_out_ext, input, [M*N][DWF]: MAC result bus.
REQ-023 SHALL have ports mac_done / block2host_val, inputs, 1 bit each: MAC finished / result valid.
REQ-024 SHALL have port block2host_rdy, output, 1 bit: host ready for the result.

Function
REQ-025 SHALL implement FSM states IDLE, REQ, WRITE, WAIT_DONE, READ, RESP.
REQ-026 IDLE SHALL drive cmd_rdy=1; on cmd_val, register a_mat, register b_mat transposed (b_reg[j*K+k]=b_mat[k*N+j]), clear err, and go to REQ.
REQ-027 REQ SHALL drive host2block_val=1; when host2block_rdy=1, go to WRITE.
REQ-028 WRITE SHALL last exactly 1 cycle: host2block_val=1, a_b_we_ext=1, operand buses = registered values; then go to WAIT_DONE.
REQ-029 Outside WRITE, operand buses SHALL be 0 and a_b_we_ext SHALL be 0.
REQ-030 WAIT_DONE SHALL drive all MAC strobes to 0; when mac_done=1, go to READ.
REQ-031 READ SHALL drive c_re_ext=1 and block2host_rdy=1; in the first cycle with block2host_val=1, capture c_data_out_ext into res_c and go to RESP; strobes drop the next cycle.
REQ-032 RESP SHALL hold res_val=1 and res_c stable until res_rdy=1, then go to IDLE; res_val=1 and res_rdy=1 in the same cycle completes in 1 cycle.
REQ-033 Latency: cmd accept to host2block_val = 1 cycle; cmd_val is ignored outside IDLE.
REQ-034 A timeout counter SHALL reset on every state entry; if it reaches TIMEOUT_CYCLES in REQ, WAIT_DONE or READ, the FSM SHALL set err=1, drop all strobes, go to IDLE, and not assert res_val.
REQ-035 The counter width SHALL be $clog2(TIMEOUT_CYCLES+1), with no wrap before expiry.
REQ-036 mac_done or block2host_val arriving in any state other than the one that consumes it SHALL be ignored.

Reset
REQ-037 rst=1 SHALL force IDLE, clear the counter, zero res_c/a_reg/b_reg, and set err=0, res_val=0 and all MAC strobes to 0 on the next edge, including mid-transaction; cmd_rdy SHALL be 1 after reset.

Structure
REQ-038 The state enum and default parameter constants SHALL live in package mac_pkg.
REQ-039 The B transposition SHALL be a combinational sub-module mac_transpose (params K, N, W).

Verification
REQ-040 4x4, A[i]=i, B[i]=i, mac_top model -> exactly one a_b_we_ext pulse with b_data_in_ext[1]=B[4]=4; res_c[0]=56, res_c[15]=506, res_val=1.
REQ-041 Hold res_rdy=0 for 10 cycles in RESP -> res_val and res_c stable; a new cmd_val is not accepted until the handshake completes.
REQ-042 Never assert mac_done, TIMEOUT_CYCLES=16 -> err=1 after 16 WAIT_DONE cycles, FSM in IDLE, res_val never 1; the next command clears err.
REQ-043 host2block_rdy delayed 5 cycles -> host2block_val held 5 cycles, then a 1-cycle WRITE.
REQ-044 Assert rst during WAIT_DONE -> all outputs reset next cycle; a subsequent command completes correctly.
REQ-045 block2host_val delayed 3 cycles in READ -> c_re_ext high 4 cycles; captured data equals the bus value in the valid cycle.
